// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and read-owner encodings.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data RAM. Requester A (CPU) has
// priority; requester B is forced through after MAX_WAIT consecutive losses.
// Reads are tracked until the RAM answers or a watchdog abandons them.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rdata_valid,

  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rdata_valid,

  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_rdata_valid,

  output logic              err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  // The watchdog fires on the last permitted RD_WAIT cycle, i.e. when the
  // count of cycles already spent waiting is TIMEOUT-1.
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;

  logic a_win, b_win;
  logic rd_done;

  // Winner selection: only in IDLE; B wins when alone or when its wait is exhausted.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (state_q == IDLE) begin
      if (b_req && (!a_req || (wait_cnt_q == WAIT_MAX))) begin
        b_win = 1'b1;
      end else if (a_req) begin
        a_win = 1'b1;
      end
    end
  end

  assign a_gnt = a_win;
  assign b_gnt = b_win;

  // RAM port mux: winner drives combinationally; RD_WAIT holds the latched read address.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (a_win) begin
      ram_addr  = a_addr;
      ram_we    = a_we;
      ram_wdata = a_wdata;
    end else if (b_win) begin
      ram_addr  = b_addr;
      ram_we    = b_we;
      ram_wdata = b_wdata;
    end else if (state_q == RD_WAIT) begin
      ram_addr  = rd_addr_q;
    end
  end

  // Read return is only honoured while a read is outstanding; stray valids in IDLE are dropped.
  assign rd_done       = (state_q == RD_WAIT) && ram_rdata_valid;
  assign a_rdata_valid = rd_done && (owner_q == OWN_A);
  assign b_rdata_valid = rd_done && (owner_q == OWN_B);
  assign a_rdata       = a_rdata_valid ? ram_rdata : '0;
  assign b_rdata       = b_rdata_valid ? ram_rdata : '0;
  assign err           = err_q;

  // FSM next state, read tracking and watchdog.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rd_addr_d = rd_addr_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    if (state_q == IDLE) begin
      if ((a_win || b_win) && !ram_we) begin
        state_d   = RD_WAIT;
        owner_d   = b_win ? OWN_B : OWN_A;
        rd_addr_d = ram_addr;
        to_cnt_d  = '0;
      end
    end else begin
      if (ram_rdata_valid) begin
        state_d = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  // Starvation counter: counts B's consecutive losses in IDLE, frozen during RD_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE) begin
      if (b_win || !b_req) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) if (!reset_n) state_q <= IDLE; else state_q <= state_d;

  // Owner of the outstanding read.
  always_ff @(posedge clk or negedge reset_n) if (!reset_n) owner_q <= OWN_A; else owner_q <= owner_d;

  // Address of the outstanding read, replayed to the RAM while waiting.
  always_ff @(posedge clk or negedge reset_n) if (!reset_n) rd_addr_q <= '0; else rd_addr_q <= rd_addr_d;

  // B starvation counter.
  always_ff @(posedge clk or negedge reset_n) if (!reset_n) wait_cnt_q <= '0; else wait_cnt_q <= wait_cnt_d;

  // Read watchdog counter.
  always_ff @(posedge clk or negedge reset_n) if (!reset_n) to_cnt_q <= '0; else to_cnt_q <= to_cnt_d;

  // Sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) if (!reset_n) err_q <= 1'b0; else err_q <= err_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read
// returns into a queue; a monitor pops and compares on every rdata_valid.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          a_req, a_we, a_gnt, a_rdata_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rdata_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_rdata_valid;
  logic          err;

  typedef struct packed {
    logic          own_b;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // RAM model: 1-cycle read latency, valid can be muted or forced.
  logic [DW-1:0] mem [0:63];
  logic          rv_q;
  logic [DW-1:0] rd_q;
  logic          ram_mute, force_v;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rdata_valid(a_rdata_valid),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rdata_valid(b_rdata_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
    rv_q <= (a_gnt | b_gnt) & ~ram_we & ~ram_mute;
    rd_q <= mem[ram_addr[7:2]];
  end
  assign ram_rdata_valid = rv_q | force_v;
  assign ram_rdata       = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic own_b, input logic [DW-1:0] d);
    exp_t e;
    e.own_b = own_b;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every read return must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_rdata_valid || b_rdata_valid) begin
        if (a_rdata_valid && b_rdata_valid) begin
          chk("both_valid", 32'(a_rdata_valid & b_rdata_valid), 0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(a_rdata_valid | b_rdata_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_owner", 32'(b_rdata_valid), 32'(e.own_b));
          chk("rd_data", b_rdata_valid ? b_rdata : a_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    ram_mute = 0; force_v = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_err", 32'(err), 0);
    reset_n = 1'b1;
    step();
    chk("idle_gnt", 32'({a_gnt, b_gnt}), 0);
    chk("idle_valid", 32'({a_rdata_valid, b_rdata_valid}), 0);

    // Preload 0x10 with 0xDEADBEEF through an A write
    a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
    #1;
    chk("pre_a_gnt", 32'(a_gnt), 1);
    chk("pre_ram_we", 32'(ram_we), 1);
    chk("pre_ram_wdata", ram_wdata, 32'hDEADBEEF);
    step();
    a_req = 0; a_we = 0;

    // A reads 0x10
    a_addr = 32'h10;
    a_req  = 1;
    #1;
    chk("rdA_gnt", 32'(a_gnt), 1);
    chk("rdA_ram_we", 32'(ram_we), 0);
    chk("rdA_ram_addr", ram_addr, 32'h10);
    push(1'b0, 32'hDEADBEEF);
    step();
    a_req = 0; a_addr = '0;
    #1;
    chk("rdA_wait_gnt", 32'(a_gnt), 0);
    chk("rdA_wait_addr", ram_addr, 32'h10);
    step();

    // A writes 0x55 to 0x20 while B reads 0x20
    a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h55;
    b_req = 1; b_we = 0; b_addr = 32'h20;
    #1;
    chk("wr_a_gnt", 32'(a_gnt), 1);
    chk("wr_b_gnt", 32'(b_gnt), 0);
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_wdata", ram_wdata, 32'h55);
    step();
    a_req = 0; a_we = 0;
    #1;
    chk("rdB_gnt", 32'(b_gnt), 1);
    chk("rdB_ram_we", 32'(ram_we), 0);
    chk("rdB_ram_addr", ram_addr, 32'h20);
    push(1'b1, 32'h55);
    step();
    b_req = 0;
    #1;
    chk("rdB_wait_gnt", 32'(b_gnt), 0);
    step();

    // Starvation: A writes every cycle, B held; B wins the 5th IDLE cycle
    a_req = 1; a_we = 1; a_addr = 32'h30;
    b_req = 1; b_we = 0; b_addr = 32'h10;
    for (int i = 1; i <= 5; i++) begin
      a_wdata = 32'(i);
      #1;
      chk($sformatf("starve1_a_gnt_%0d", i), 32'(a_gnt), 32'(i < 5));
      chk($sformatf("starve1_b_gnt_%0d", i), 32'(b_gnt), 32'(i == 5));
      if (i == 5) push(1'b1, 32'hDEADBEEF);
      step();
    end
    b_req = 0;
    #1;
    chk("starve_rdwait_a_gnt", 32'(a_gnt), 0);
    chk("starve_rdwait_we", 32'(ram_we), 0);
    step();
    // Counter must have restarted from 0: B again waits four cycles
    b_req = 1; b_we = 1; b_addr = 32'h34; b_wdata = 32'h77;
    for (int i = 1; i <= 5; i++) begin
      a_wdata = 32'h100 + 32'(i);
      #1;
      chk($sformatf("starve2_a_gnt_%0d", i), 32'(a_gnt), 32'(i < 5));
      chk($sformatf("starve2_b_gnt_%0d", i), 32'(b_gnt), 32'(i == 5));
      if (i == 5) chk("starve2_wdata", ram_wdata, 32'h77);
      step();
    end
    a_req = 0; a_we = 0; b_req = 0; b_we = 0;

    // Read timeout: RAM never answers
    ram_mute = 1;
    a_req = 1; a_addr = 32'h40;
    #1;
    chk("to_a_gnt", 32'(a_gnt), 1);
    step();
    a_req = 0;
    b_req = 1; b_we = 1; b_addr = 32'h38; b_wdata = 32'h99;
    for (int i = 1; i <= 15; i++) begin
      #1;
      chk($sformatf("to_err_%0d", i), 32'(err), 0);
      chk($sformatf("to_b_gnt_%0d", i), 32'(b_gnt), 0);
      step();
    end
    #1;
    chk("to_err_set", 32'(err), 1);
    chk("to_b_gnt_after", 32'(b_gnt), 1);
    chk("to_b_ram_we", 32'(ram_we), 1);
    step();
    b_req = 0; b_we = 0;
    force_v = 1;   // late valid arriving in IDLE must be ignored
    step();
    force_v = 0;
    #1;
    chk("to_err_sticky", 32'(err), 1);
    step();

    // Reset pulsed during RD_WAIT
    a_req = 1; a_we = 0; a_addr = 32'h10;
    #1;
    chk("rst_rd_a_gnt", 32'(a_gnt), 1);
    step();
    a_req = 0; a_addr = '0;
    #1;
    chk("rst_rd_wait_addr", ram_addr, 32'h10);
    reset_n = 0;
    #1;
    chk("rst_rd_err_clr", 32'(err), 0);
    chk("rst_rd_addr_clr", ram_addr, 0);
    reset_n = 1;
    force_v = 1;
    step();
    step();
    force_v = 0;
    ram_mute = 0;
    step();

    // A and B both read: A first, B in the first IDLE cycle afterwards
    a_req = 1; a_we = 0; a_addr = 32'h34;
    b_req = 1; b_we = 0; b_addr = 32'h10;
    #1;
    chk("both_a_gnt", 32'(a_gnt), 1);
    chk("both_b_gnt0", 32'(b_gnt), 0);
    push(1'b0, 32'h77);
    step();
    a_req = 0;
    #1;
    chk("both_wait_b_gnt", 32'(b_gnt), 0);
    step();
    #1;
    chk("both_b_gnt1", 32'(b_gnt), 1);
    push(1'b1, 32'hDEADBEEF);
    step();
    b_req = 0;
    step();
    step();

    chk("pending_responses", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
